mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative-latency HI/LO multiply/divide unit in the EX stage.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and MTHI/MTLO with single-cycle writes.
- Drives `busy` to the pipeline hazard controller, which stalls any MULTDIV-class instruction in ID while `busy` is high.
- Accepts the controller's `dis_MULTDIV` as `disable`, so a flushed instruction never starts or writes.

Parameters:
- MULT_CYCLES, 5, busy cycles after a MULT/MULTU start before HI/LO update (≥1)
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU start before HI/LO update (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- op  in  3  EX-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- rs  in  32  forwarded rs operand
- rt  in  32  forwarded rt operand
- disable  in  1  suppresses any op in the current cycle (flush/exception)
- busy  out  1  unit occupied; includes the start cycle
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
Reset and registers
- reset asserted, asynchronously: state=IDLE, counter=0, hi=0, lo=0, pending results=0, busy=0.
- reset mid-operation aborts the operation; the pending result is discarded.

States
- IDLE, MUL_RUN, DIV_RUN.

Start
- In cycle C0 a start occurs when state=IDLE, disable=0 and op∈{1..4}.
- In the start cycle:
  - busy=1 combinationally.
  - The full result is computed from rs/rt and stored in pending_hi/pending_lo at the C0 edge.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - state becomes MUL_RUN or DIV_RUN.

Run
- In RUN, busy=1 and counter decrements each edge.
- The edge where counter==1 does three things: commits pending to hi/lo, returns to IDLE, clears busy.
- Result: busy is high in C0..CN, where N is the parameter. New hi/lo values and busy=0 are visible in C(N+1).
- Total busy cycles = N+1.

Busy signal
- busy = (state!=IDLE) | start.
- start depends on op, disable and state, not on busy, so there is no combinational loop.

Arithmetic
- MULT: signed 32×32→64 product; hi=prod[63:32], lo=prod[31:0].
- MULTU: same, unsigned.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend (rs).
- DIVU: unsigned.
- Divide by zero (rt==0): lo=32'hFFFFFFFF, hi=rs, same latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0.

MTHI/MTLO
- When state=IDLE and disable=0: hi (or lo) is written with rs at the C0 edge. busy is not asserted.

disable
- disable=1 suppresses any start or MTHI/MTLO in that cycle.
- An operation already in RUN is not affected and completes normally.

op arriving while not IDLE
- Any op∈{1..6} arriving while state≠IDLE is ignored, including MTHI/MTLO. The controller's stall prevents this.
- A new start is accepted in C(N+1), the first IDLE cycle.

hi/lo outputs
- Change only on commit, on an MTHI/MTLO write, or on reset.
- No bypass of pending results.

Test Plan:
- Reset mid-operation: assert reset in C3 of a DIV → hi=lo=0 and busy=0 immediately (asynchronous); the next op starts cleanly.
- MULT signed, default params: rs=0xFFFFFFFE (-2), rt=3, op=1 in C0 → busy=1 in C0..C5; in C6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 6 cycles.
- DIV/DIVU:
  - DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 11 cycles.
  - DIVU rs=7, rt=0 → lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- disable and in-flight behaviour:
  - op=1 with disable=1 → busy=0 in that cycle, and hi/lo unchanged forever after.
  - disable pulsed during the run of an in-flight MULT → the MULT still commits in C6.
- MTHI/MTLO and back-to-back ops:
  - MTLO rs=0x1234 while IDLE → lo=0x1234 next cycle, busy never asserted.
  - MTHI presented during DIV_RUN → ignored.
  - A MULT presented in C6 after an earlier MULT's commit starts immediately.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO multiply/divide unit.
// `dis` carries the controller's dis_MULTDIV flush signal.
interface mult_div_unit_if;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        dis;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output op, output rs, output rt, output dis,
                  input busy, input hi, input lo);
  modport slave  (input op, input rs, input rt, input dis,
                  output busy, output hi, output lo);
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency HI/LO multiply/divide unit. The result is computed in the start cycle and
// parked in pending registers until the run counter expires, then committed to HI/LO.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {StIdle, StMulRun, StDivRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic        idle, is_mul, is_div, start;
  logic        signed_op, neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, mag_b_safe, uq, ur, quo, rem;
  logic [63:0] prod_mag, prod;

  assign idle   = (state_q == StIdle);
  assign is_mul = (bus.op == OpMult) || (bus.op == OpMultu);
  assign is_div = (bus.op == OpDiv) || (bus.op == OpDivu);
  assign start  = idle && !bus.dis && (is_mul || is_div);

  // Signed ops work on magnitudes and fix the sign afterwards; 0x80000000 / -1 falls out
  // naturally as quotient 0x80000000, remainder 0.
  assign signed_op  = (bus.op == OpMult) || (bus.op == OpDiv);
  assign neg_a      = signed_op & bus.rs[31];
  assign neg_b      = signed_op & bus.rt[31];
  assign mag_a      = neg_a ? -bus.rs : bus.rs;
  assign mag_b      = neg_b ? -bus.rt : bus.rt;
  assign prod_mag   = {32'd0, mag_a} * {32'd0, mag_b};
  assign prod       = (neg_a ^ neg_b) ? -prod_mag : prod_mag;

  assign div_zero   = (bus.rt == 32'd0);
  assign mag_b_safe = div_zero ? 32'd1 : mag_b;
  assign uq         = mag_a / mag_b_safe;
  assign ur         = mag_a % mag_b_safe;
  assign quo        = div_zero ? 32'hFFFF_FFFF : ((neg_a ^ neg_b) ? -uq : uq);
  assign rem        = div_zero ? bus.rs : (neg_a ? -ur : ur);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.dis) begin
          if (is_mul) begin
            state_d   = StMulRun;
            cnt_d     = CntW'(MULT_CYCLES);
            pend_hi_d = prod[63:32];
            pend_lo_d = prod[31:0];
          end else if (is_div) begin
            state_d   = StDivRun;
            cnt_d     = CntW'(DIV_CYCLES);
            pend_hi_d = rem;
            pend_lo_d = quo;
          end else if (bus.op == OpMthi) begin
            hi_d = bus.rs;
          end else if (bus.op == OpMtlo) begin
            lo_d = bus.rs;
          end
        end
      end
      StMulRun, StDivRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // start is derived from op/dis/state only, so busy has no path back into itself.
  assign bus.busy = !idle || start;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random ops against an arithmetic model
// of HI/LO, plus latency, disable, ignore-while-busy, back-to-back and async reset scenarios.
module tb_mult_div_unit;

  localparam int MulN = 5;
  localparam int DivN = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if itf ();

  mult_div_unit #(
    .MULT_CYCLES(MulN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (itf.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi, m_lo;

  // Reference {hi, lo} computed with plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              q, r;
    case (o)
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o);
    return (o <= 3'd2) ? MulN : DivN;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic d);
    itf.op  = o;
    itf.rs  = a;
    itf.rt  = b;
    itf.dis = d;
  endtask

  // Issues one op and follows it until busy drops (bounded). Returns busy-cycle count and the
  // hi/lo seen in the last busy cycle; leaves time at the negedge of the first idle cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bc, output logic [31:0] h_pre, output logic [31:0] l_pre);
    bc = 0;
    step();
    drive(o, a, b, 1'b0);
    @(negedge clk);
    h_pre = itf.hi;
    l_pre = itf.lo;
    while (itf.busy === 1'b1 && bc < 64) begin
      bc++;
      h_pre = itf.hi;
      l_pre = itf.lo;
      step();
      drive(3'd0, $urandom, $urandom, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (itf.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", itf.busy); end
    n_cmp++;
    if (itf.hi !== 32'd0) begin n_err++; $display("FAIL reset hi: got %h expected 0", itf.hi); end
    n_cmp++;
    if (itf.lo !== 32'd0) begin n_err++; $display("FAIL reset lo: got %h expected 0", itf.lo); end
    step();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mt();
    logic [2:0]  o;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      o = (i % 2 == 0) ? 3'd6 : 3'd5;
      v = (i == 0) ? 32'h0000_1234 : $urandom;
      step();
      drive(o, v, $urandom, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (itf.busy !== 1'b0) begin
        n_err++; $display("FAIL mt[%0d] busy: got %b expected 0", i, itf.busy);
      end
      if (o == 3'd5) m_hi = v; else m_lo = v;
      step();
      drive(3'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (itf.hi !== m_hi || itf.lo !== m_lo) begin
        n_err++;
        $display("FAIL mt[%0d] hi/lo: got %h/%h expected %h/%h", i, itf.hi, itf.lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_arith();
    logic [2:0]  d_op [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd3, 3'd4};
    logic [31:0] d_rs [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                              32'h8000_0000, 32'hFFFF_FFF0, 32'hDEAD_BEEF};
    logic [31:0] d_rt [7] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0,
                              32'd16};
    logic [2:0]  o;
    logic [31:0] a, b, h_pre, l_pre;
    logic [63:0] exp;
    int          bc;
    for (int i = 0; i < 31; i++) begin
      if (i < 7) begin
        o = d_op[i]; a = d_rs[i]; b = d_rt[i];
      end else begin
        o = 3'($urandom_range(1, 4));
        a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      end
      exp = ref_result(o, a, b);
      run_op(o, a, b, bc, h_pre, l_pre);
      n_cmp++;
      if (bc != lat(o) + 1) begin
        n_err++; $display("FAIL arith[%0d] busy cycles: got %0d expected %0d", i, bc, lat(o) + 1);
      end
      n_cmp++;
      if (h_pre !== m_hi || l_pre !== m_lo) begin
        n_err++;
        $display("FAIL arith[%0d] early hi/lo: got %h/%h expected %h/%h", i, h_pre, l_pre,
                 m_hi, m_lo);
      end
      n_cmp++;
      if (itf.hi !== exp[63:32] || itf.lo !== exp[31:0]) begin
        n_err++;
        $display("FAIL arith[%0d] op%0d %h,%h: got %h/%h expected %h/%h", i, o, a, b,
                 itf.hi, itf.lo, exp[63:32], exp[31:0]);
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  task automatic test_disable();
    logic bad;
    for (int o = 1; o <= 6; o++) begin
      step();
      drive(3'(o), $urandom | 32'd1, $urandom | 32'd1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (itf.busy !== 1'b0) begin
        n_err++; $display("FAIL disable op%0d busy: got %b expected 0", o, itf.busy);
      end
    end
    step();
    drive(3'd0, 32'd0, 32'd0, 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (itf.busy !== 1'b0 || itf.hi !== m_hi || itf.lo !== m_lo) bad = 1'b1;
      step();
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL disable aftermath: got %h/%h expected %h/%h busy 0", itf.hi, itf.lo,
               m_hi, m_lo);
    end
  endtask

  task automatic test_disable_inflight();
    logic [31:0] a, b;
    logic [63:0] exp;
    logic        bad;
    a = $urandom; b = $urandom;
    exp = ref_result(3'd1, a, b);
    bad = 1'b0;
    step();
    drive(3'd1, a, b, 1'b0);
    for (int k = 1; k <= MulN; k++) begin
      step();
      drive(3'(k % 3), $urandom, $urandom, k[0]);
      @(negedge clk);
      if (itf.busy !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL inflight busy: got drop expected 1 through C%0d", MulN); end
    step();
    drive(3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (itf.busy !== 1'b0 || itf.hi !== exp[63:32] || itf.lo !== exp[31:0]) begin
      n_err++;
      $display("FAIL inflight commit: got %b %h/%h expected 0 %h/%h", itf.busy, itf.hi, itf.lo,
               exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic test_mthi_during_div();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic        bad;
    a = $urandom; b = ($urandom >> 8) | 32'd1;
    exp = ref_result(3'd3, a, b);
    bad = 1'b0;
    step();
    drive(3'd3, a, b, 1'b0);
    for (int k = 1; k <= DivN; k++) begin
      case (k)
        2: o = 3'd5;
        3: o = 3'd6;
        4: o = 3'd1;
        5: o = 3'd4;
        6: o = 3'd7;
        default: o = 3'd0;
      endcase
      step();
      drive(o, $urandom, $urandom, 1'b0);
      @(negedge clk);
      if (itf.busy !== 1'b1 || itf.hi !== m_hi || itf.lo !== m_lo) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL ignore-busy run: got %h/%h expected %h/%h", itf.hi, itf.lo, m_hi, m_lo);
    end
    step();
    drive(3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (itf.busy !== 1'b0 || itf.hi !== exp[63:32] || itf.lo !== exp[31:0]) begin
      n_err++;
      $display("FAIL ignore-busy commit: got %b %h/%h expected 0 %h/%h", itf.busy, itf.hi, itf.lo,
               exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    logic [31:0] a, b, c, d;
    logic        bad;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    e1 = ref_result(3'd1, a, b);
    e2 = ref_result(3'd2, c, d);
    step();
    drive(3'd1, a, b, 1'b0);
    for (int k = 1; k <= MulN; k++) begin step(); drive(3'd0, 32'd0, 32'd0, 1'b0); end
    step();
    drive(3'd2, c, d, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (itf.busy !== 1'b1 || itf.hi !== e1[63:32] || itf.lo !== e1[31:0]) begin
      n_err++;
      $display("FAIL b2b restart: got %b %h/%h expected 1 %h/%h", itf.busy, itf.hi, itf.lo,
               e1[63:32], e1[31:0]);
    end
    bad = 1'b0;
    for (int k = 1; k <= MulN; k++) begin
      step();
      drive(3'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      if (itf.busy !== 1'b1 || itf.hi !== e1[63:32]) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL b2b second run: got %h expected %h busy 1", itf.hi, e1[63:32]); end
    step();
    @(negedge clk);
    n_cmp++;
    if (itf.busy !== 1'b0 || itf.hi !== e2[63:32] || itf.lo !== e2[31:0]) begin
      n_err++;
      $display("FAIL b2b commit: got %b %h/%h expected 0 %h/%h", itf.busy, itf.hi, itf.lo,
               e2[63:32], e2[31:0]);
    end
    m_hi = e2[63:32];
    m_lo = e2[31:0];
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] a, b, h_pre, l_pre;
    logic [63:0] exp;
    int          bc;
    step();
    drive(3'd5, 32'hA5A5_0001, 32'd0, 1'b0);
    step();
    drive(3'd3, $urandom, 32'd3, 1'b0);
    step();
    drive(3'd0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (itf.busy !== 1'b0 || itf.hi !== 32'd0 || itf.lo !== 32'd0) begin
      n_err++;
      $display("FAIL async reset: got %b %h/%h expected 0 0/0", itf.busy, itf.hi, itf.lo);
    end
    step();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    n_cmp++;
    if (itf.busy !== 1'b0 || itf.hi !== 32'd0) begin
      n_err++; $display("FAIL post reset: got %b %h expected 0 0", itf.busy, itf.hi);
    end
    a = $urandom; b = $urandom;
    exp = ref_result(3'd1, a, b);
    run_op(3'd1, a, b, bc, h_pre, l_pre);
    n_cmp++;
    if (bc != MulN + 1 || itf.hi !== exp[63:32] || itf.lo !== exp[31:0]) begin
      n_err++;
      $display("FAIL restart after reset: got %0d %h/%h expected %0d %h/%h", bc, itf.hi, itf.lo,
               MulN + 1, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    reset = 1'b1;
    drive(3'd0, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_mt();
    test_arith();
    test_disable();
    test_disable_inflight();
    test_mthi_during_div();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
